// File: rtl/adc_frame_avg.sv
// adc_frame_avg: checks channel order, averages 2^AVG_LOG2 frames per channel and streams one buffered frame
module adc_frame_avg #(
  parameter int NCH      = 6,
  parameter int AVG_LOG2 = 2,
  parameter int DW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample_data,
  input  logic [2:0]    sample_ch,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [2:0]    out_ch,
  output logic          out_last,
  output logic          overflow,
  output logic          sync_err,
  output logic          busy
);
  localparam int AW = DW + AVG_LOG2;
  localparam int FW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [FW-1:0] LASTF = FW'((1 << AVG_LOG2) - 1);
  localparam logic [2:0] LASTC = 3'(NCH - 1);

  typedef enum logic {WAIT_CH0, COLLECT} cstate_t;
  typedef enum logic {OUT_EMPTY, OUT_SEND} ostate_t;

  cstate_t              r_cstate;
  ostate_t              r_ostate;
  logic [2:0]           r_exp_ch;
  logic [FW-1:0]        r_frame;
  logic signed [AW-1:0] r_acc [NCH];
  logic [DW-1:0]        r_obuf [NCH];
  logic [2:0]           r_out_ch;
  logic                 r_overflow;
  logic                 r_sync_err;

  logic signed [AW-1:0] w_sx;
  logic signed [AW-1:0] w_sum;
  logic                 w_hit;
  logic                 w_done;
  logic [DW-1:0]        w_res [NCH];

  assign w_sx   = AW'($signed(sample_data));
  assign w_hit  = enable && sample_valid && r_cstate == COLLECT && sample_ch == r_exp_ch;
  assign w_sum  = (r_frame == '0) ? w_sx : r_acc[r_exp_ch] + w_sx;
  assign w_done = w_hit && r_exp_ch == LASTC && r_frame == LASTF;

  // the last channel's average must include the sample completing the result
  for (genvar g = 0; g < NCH; g++) begin : g_res
    logic signed [AW-1:0] w_src;
    logic signed [AW-1:0] w_sh;
    assign w_src    = (g == NCH - 1) ? w_sum : r_acc[g];
    assign w_sh     = w_src >>> AVG_LOG2;
    assign w_res[g] = w_sh[DW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cstate   <= WAIT_CH0;
      r_exp_ch   <= '0;
      r_frame    <= '0;
      r_acc      <= '{default: '0};
      r_sync_err <= 1'b0;
    end else begin
      r_sync_err <= 1'b0;
      if (!enable) r_cstate <= WAIT_CH0;
      else if (sample_valid) begin
        if (w_hit) begin
          r_acc[r_exp_ch] <= w_sum;
          r_exp_ch        <= (r_exp_ch == LASTC) ? 3'd0 : r_exp_ch + 3'd1;
          if (r_exp_ch == LASTC) r_frame <= r_frame + 1'b1;
          if (w_done) r_cstate <= WAIT_CH0;
        end else begin
          if (r_cstate == COLLECT) r_sync_err <= 1'b1;
          if (sample_ch == 3'd0) begin
            r_acc[0] <= w_sx;
            r_exp_ch <= 3'd1;
            r_frame  <= '0;
            r_cstate <= COLLECT;
          end else r_cstate <= WAIT_CH0;
        end
      end
    end
  end

  // a completion coinciding with the final handshake still sees OUT_SEND and overflows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ostate   <= OUT_EMPTY;
      r_out_ch   <= '0;
      r_obuf     <= '{default: '0};
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (r_ostate == OUT_SEND && out_ready) begin
        r_out_ch <= out_last ? 3'd0 : r_out_ch + 3'd1;
        if (out_last) r_ostate <= OUT_EMPTY;
      end
      if (w_done) begin
        if (r_ostate == OUT_EMPTY) begin
          r_obuf   <= w_res;
          r_out_ch <= 3'd0;
          r_ostate <= OUT_SEND;
        end else r_overflow <= 1'b1;
      end
    end
  end

  assign out_valid = r_ostate == OUT_SEND;
  assign out_ch    = r_out_ch;
  assign out_data  = r_obuf[r_out_ch];
  assign out_last  = out_valid && r_out_ch == LASTC;
  assign overflow  = r_overflow;
  assign sync_err  = r_sync_err;
  assign busy      = r_cstate == COLLECT || out_valid;
endmodule

// File: tb/tb_adc_frame_avg.sv
// tb_adc_frame_avg: scoreboard bench for adc_frame_avg with default parameters (6 channels, 4-frame average)
module tb_adc_frame_avg;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = '0;
  logic [2:0]  sample_ch = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [2:0]  out_ch;
  logic        out_last;
  logic        overflow;
  logic        sync_err;
  logic        busy;

  adc_frame_avg dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
    .sample_data(sample_data), .sample_ch(sample_ch), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
    .overflow(overflow), .sync_err(sync_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ch;
    logic [15:0] d;
    logic        last;
  } exp_t;

  exp_t               q[$];
  exp_t               e_mon;
  logic signed [15:0] frm [4][6];
  int                 n_cmp = 0;
  int                 n_err = 0;
  int                 ov_n = 0;
  int                 se_n = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (overflow) ov_n++;
      if (sync_err) se_n++;
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("extra_word", 1, 0);
        else begin
          e_mon = q.pop_front();
          check("out_data", 32'(out_data), 32'(e_mon.d));
          check("out_ch", 32'(out_ch), 32'(e_mon.ch));
          check("out_last", 32'(out_last), 32'(e_mon.last));
        end
      end
    end
  end

  task automatic drive_sample(input logic [2:0] c, input logic [15:0] d);
    sample_ch    = c;
    sample_data  = d;
    sample_valid = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
  endtask

  task automatic send_frames(input bit push);
    exp_t e;
    int   s;
    if (push)
      for (int c = 0; c < 6; c++) begin
        s = 0;
        for (int f = 0; f < 4; f++) s += int'(frm[f][c]);
        s = s >>> 2;
        e.ch = 3'(c);
        e.d = s[15:0];
        e.last = (c == 5);
        q.push_back(e);
      end
    for (int f = 0; f < 4; f++)
      for (int c = 0; c < 6; c++) drive_sample(3'(c), frm[f][c]);
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while (i < 100 && (q.size() != 0 || out_valid)) begin
      @(posedge clk);
      #2;
      i++;
    end
    check("drain_done", 32'(q.size() == 0 && !out_valid), 1);
  endtask

  task automatic fill(input int base, input int step);
    for (int f = 0; f < 4; f++)
      for (int c = 0; c < 6; c++) frm[f][c] = 16'(base + step * c + f);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_flags", 32'({overflow, sync_err, out_last}), 0);
    check("rst_data", 32'(out_data), 0);
    #1 rst = 1'b0;

    // basic ordered frames: averages 1,17,...,81
    fill(0, 16);
    check("pre_valid", 32'(out_valid), 0);
    send_frames(1);
    check("latency1", 32'(out_valid), 1);
    check("first_ch", 32'(out_ch), 0);
    check("first_data", 32'(out_data), 32'h1);
    wait_drain();

    // signed floor rounding
    for (int f = 0; f < 4; f++)
      for (int c = 0; c < 6; c++) frm[f][c] = 16'hFFFF;
    frm[0][0] = 16'hFFFD;
    frm[1][0] = 16'hFFFE;
    frm[2][0] = 16'hFFFE;
    frm[3][0] = 16'hFFFE;
    send_frames(1);
    check("neg_ch0", 32'(out_data), 32'hFFFD);
    wait_drain();

    // backpressure and overflow
    out_ready = 1'b0;
    fill(100, 8);
    send_frames(1);
    check("hold_valid", 32'(out_valid), 1);
    fill(-500, 3);
    send_frames(0);
    check("ovf_pulse", 32'(overflow), 1);
    check("hold_ch", 32'(out_ch), 0);
    check("hold_data", 32'(out_data), 32'(q[0].d));
    repeat (3) @(posedge clk);
    #1 check("ovf_count", ov_n, 1);
    out_ready = 1'b1;
    wait_drain();
    repeat (5) @(posedge clk);
    #1 check("ovf_total", ov_n, 1);

    // sync errors
    drive_sample(3'd0, 16'd5);
    drive_sample(3'd1, 16'd6);
    drive_sample(3'd3, 16'd7);
    check("serr_pulse", 32'(sync_err), 1);
    check("serr_busy", 32'(busy), 0);
    @(posedge clk);
    #1 check("serr_one", se_n, 1);
    drive_sample(3'd0, 16'd9);
    drive_sample(3'd1, 16'd9);
    drive_sample(3'd2, 16'd9);
    fill(1000, -40);
    send_frames(1);
    wait_drain();
    check("serr_two", se_n, 2);

    // enable drop aborts partial frame silently
    fill(7, 2);
    for (int i = 0; i < 10; i++) drive_sample(3'(i % 6), 16'h7000);
    enable = 1'b0;
    drive_sample(3'd4, 16'h7000);
    drive_sample(3'd0, 16'h7000);
    check("dis_busy", 32'(busy), 0);
    enable = 1'b1;
    send_frames(1);
    wait_drain();
    check("en_serr", se_n, 2);

    // reset mid-drain
    out_ready = 1'b0;
    fill(200, 5);
    send_frames(1);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    check("mid_ch", 32'(out_ch), 2);
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_flags", 32'({overflow, sync_err}), 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("post_busy", 32'(busy), 0);
    out_ready = 1'b1;
    fill(-30, 11);
    send_frames(1);
    wait_drain();
    check("final_ovf", ov_n, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/adc_frame_avg.md
Name: adc_frame_avg

Overview:
- Downstream consumer of the six-channel serial ADC capture stage. Takes its per-word sample strobe, 16-bit sample and channel index.
- Checks that channels arrive in order 0..NCH-1 and accumulates 2^AVG_LOG2 complete frames per channel.
- Emits one averaged frame as a valid/ready word stream, with a one-frame output buffer so the next accumulation overlaps the drain.
- All inputs are synchronous to clk; the capture stage runs on the same clock.

Parameters:
NCH, 6, channels per frame (2..8)
AVG_LOG2, 2, log2 of frames averaged (0..6)
DW, 16, sample width, two's complement

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
enable  in  1  accumulation enable; low = abort partial frame and hold in WAIT_CH0
sample_valid  in  1  one-cycle strobe, new sample present
sample_data  in  DW  signed sample
sample_ch  in  3  channel of sample_data
out_valid  out  1  averaged word available
out_ready  in  1  consumer accepts word when out_valid&&out_ready
out_data  out  DW  averaged signed value
out_ch  out  3  channel of out_data
out_last  out  1  high with channel NCH-1 word
overflow  out  1  one-cycle pulse: completed average dropped, output buffer still occupied
sync_err  out  1  one-cycle pulse: channel sequence violation
busy  out  1  high when not in WAIT_CH0 or output buffer non-empty

Behaviour:
- Reset: all outputs 0; accumulators and output buffer cleared; collector in WAIT_CH0; output side in OUT_EMPTY.
- Accumulator per channel is DW+AVG_LOG2 bits, sign-extended add.
- Average = arithmetic shift right by AVG_LOG2, truncating toward minus infinity. Low DW bits are taken; no saturation is needed.
- Collector FSM:
  - WAIT_CH0: samples with sample_ch!=0 are ignored silently. A sample with ch 0 is loaded into acc[0] (overwrite), sets exp_ch=1, frame_idx=0, and moves to COLLECT.
  - COLLECT, sample_ch==exp_ch: acc[exp_ch] += sample. If frame_idx==0, the accumulator is overwritten instead of added. exp_ch increments.
  - At exp_ch==NCH-1: exp_ch wraps to 0 and frame_idx increments.
  - At frame_idx==2^AVG_LOG2-1 with ch NCH-1: a result is complete and the collector returns to WAIT_CH0.
  - COLLECT, sample_ch!=exp_ch: sync_err pulses the next cycle and the partial data is discarded. If sample_ch==0, the sample starts a new frame (state COLLECT, exp_ch=1, frame_idx=0); otherwise go to WAIT_CH0.
  - enable low: the collector is forced to WAIT_CH0 and incoming samples are ignored. No sync_err is raised; the output side is unaffected.
- Result transfer, in the completion cycle:
  - The final sample's contribution is included in the buffered result.
  - If the output side is OUT_EMPTY, the shifted results are copied into the NCH-entry out buffer. out_valid goes 1 on the next clk (latency 1 from the last sample_valid), with out_ch=0.
  - Else overflow pulses the next cycle and the result is dropped; the buffer contents are untouched.
- Output FSM:
  - OUT_EMPTY -> OUT_SEND on load.
  - In OUT_SEND, out_data/out_ch/out_last are stable while out_valid && !out_ready.
  - On handshake, out_ch increments. On handshake with out_last, return to OUT_EMPTY and drop out_valid the next cycle.
  - With out_ready held high, the six words leave on consecutive cycles.
- Simultaneity: a completion in the same cycle as the final handshake (out_last accepted) counts as buffer-occupied, so overflow is raised. Sample strobes arriving back-to-back every cycle must be accepted.
- Reset asserted mid-frame or mid-drain clears everything immediately; out_valid falls asynchronously.

Test Plan:
1. AVG_LOG2=2, out_ready=1, 4 ordered frames, sample for ch k, frame f = 16k+f -> out_data 1,17,33,49,65,81 on ch 0..5. out_last only on ch5. First out_valid one cycle after the 24th sample_valid.
2. Signed rounding: ch0 samples 0xFFFD,0xFFFE,0xFFFE,0xFFFE (sum -9) -> out_data 0xFFFD. All-0xFFFF samples -> 0xFFFF.
3. Backpressure: out_ready=0, two full results -> first result held stable, overflow pulses exactly once for the second. Releasing out_ready drains the first result's six words only.
4. Sync error: channel sequence 0,1,3 -> sync_err one pulse, no output, busy drops. Sequence 0,1,2,0 -> sync_err, and that ch0 sample begins the next frame, so 4 further-aligned frames give correct averages.
5. enable dropped after 10 samples, then raised with 24 fresh samples -> no sync_err, output reflects only the fresh 24.
6. rst asserted while out_valid=1 at out_ch=2 -> out_valid, overflow and sync_err are 0 immediately. After release, busy=0 and the next 24 samples give a clean result.
